// File: rtl/ct_fcnvt_wb_buf_if.sv
// Writeback request/grant bundle between the fcnvt writeback buffer and the shared VFPU
// writeback port. The buffer is the master (it drives the request and the head entry).
interface ct_fcnvt_wb_buf_if #(
  parameter int unsigned DATA_W = 64
);
  logic              wb_req;
  logic [DATA_W-1:0] wb_data;
  logic [4:0]        wb_fflags;
  logic [6:0]        wb_preg;
  logic              wb_grant;

  modport master (
    output wb_req,
    output wb_data,
    output wb_fflags,
    output wb_preg,
    input  wb_grant
  );

  modport slave (
    input  wb_req,
    input  wb_data,
    input  wb_fflags,
    input  wb_preg,
    output wb_grant
  );
endinterface

// File: rtl/ct_fcnvt_wb_buf.sv
// Writeback-side buffer for the vector FP convert pipe. Captures EX3 results in a circular
// FIFO, presents the head entry to the shared writeback port, and hands credits back to
// EX1 so that an op launched into the non-stallable EX1..EX3 pipe always has a slot.
module ct_fcnvt_wb_buf #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst,
  input  logic              ex1_pipedown,
  input  logic              ex3_pipedown,
  input  logic [DATA_W-1:0] ex3_result,
  input  logic [4:0]        ex3_fflags,
  input  logic [6:0]        ex3_preg,
  input  logic              rtu_yy_xx_flush,
  ct_fcnvt_wb_buf_if.master wb,
  output logic              fcnvt_credit_ok,
  output logic              fcnvt_buf_err
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Entry storage; contents are don't-care while empty, so no reset.
  logic [DATA_W-1:0] data_q   [DEPTH];
  logic [4:0]        fflags_q [DEPTH];
  logic [6:0]        preg_q   [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] credit_q, credit_d;
  logic             buf_err_q, buf_err_d;

  logic wb_req_int;
  logic pop;
  logic push_ok;
  logic pop_ok;
  logic ex1_ok;
  logic ex1_err;
  logic push_err;
  logic grant_err;

  // Handshake decode: a full-buffer push or a zero-credit launch is only legal alongside a pop.
  always_comb begin
    wb_req_int = (cnt_q != '0);
    pop        = wb_req_int && wb.wb_grant;
    ex1_err    = ex1_pipedown && (credit_q == '0) && !pop;
    push_err   = ex3_pipedown && (cnt_q == CNT_FULL) && !pop;
    grant_err  = wb.wb_grant && !wb_req_int;
    // Flush discards every event of its own cycle.
    pop_ok     = pop && !rtu_yy_xx_flush;
    push_ok    = ex3_pipedown && !push_err && !rtu_yy_xx_flush;
    ex1_ok     = ex1_pipedown && !ex1_err && !rtu_yy_xx_flush;
  end

  // Next-state for pointers, occupancy, credits and the sticky error flag.
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    credit_d  = credit_q;
    buf_err_d = buf_err_q;

    if (rtu_yy_xx_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
      credit_d = CNT_FULL;
    end else begin
      if (pop_ok) begin
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
      end
      if (push_ok) begin
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
      end
      if (push_ok && !pop_ok) begin
        cnt_d = cnt_q + CNT_ONE;
      end else if (pop_ok && !push_ok) begin
        cnt_d = cnt_q - CNT_ONE;
      end
      if (ex1_ok && !pop_ok) begin
        credit_d = credit_q - CNT_ONE;
      end else if (pop_ok && !ex1_ok && (credit_q != CNT_FULL)) begin
        credit_d = credit_q + CNT_ONE;
      end
      buf_err_d = buf_err_q | ex1_err | push_err | grant_err;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      credit_q  <= CNT_FULL;
      buf_err_q <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      credit_q  <= credit_d;
      buf_err_q <= buf_err_d;
    end
  end

  // Entry write on an accepted push; reset/flush gate it through push_ok and cnt.
  always_ff @(posedge forever_cpuclk) begin
    if (push_ok && !cpurst) begin
      data_q[wr_ptr_q]   <= ex3_result;
      fflags_q[wr_ptr_q] <= ex3_fflags;
      preg_q[wr_ptr_q]   <= ex3_preg;
    end
  end

  // Outputs come only from registered state; no ex3-to-wb bypass.
  always_comb begin
    wb.wb_req       = wb_req_int;
    wb.wb_data      = data_q[rd_ptr_q];
    wb.wb_fflags    = fflags_q[rd_ptr_q];
    wb.wb_preg      = preg_q[rd_ptr_q];
    fcnvt_credit_ok = (credit_q != '0);
    fcnvt_buf_err   = buf_err_q;
  end

endmodule

// File: tb/tb_ct_fcnvt_wb_buf.sv
// Self-checking bench for ct_fcnvt_wb_buf: directed scenarios followed by a randomized run,
// all checked against a queue-based model of the buffer, credits and error flag.
module tb_ct_fcnvt_wb_buf;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  ff;
    logic [6:0]  preg;
  } ent_t;

  logic        forever_cpuclk = 1'b0;
  logic        cpurst;
  logic        ex1_pipedown;
  logic        ex3_pipedown;
  logic [63:0] ex3_result;
  logic [4:0]  ex3_fflags;
  logic [6:0]  ex3_preg;
  logic        rtu_yy_xx_flush;
  logic        fcnvt_credit_ok;
  logic        fcnvt_buf_err;

  ct_fcnvt_wb_buf_if #(.DATA_W(64)) wb_if ();

  ct_fcnvt_wb_buf #(.DATA_W(64), .DEPTH(DEPTH)) dut (
    .forever_cpuclk  (forever_cpuclk),
    .cpurst          (cpurst),
    .ex1_pipedown    (ex1_pipedown),
    .ex3_pipedown    (ex3_pipedown),
    .ex3_result      (ex3_result),
    .ex3_fflags      (ex3_fflags),
    .ex3_preg        (ex3_preg),
    .rtu_yy_xx_flush (rtu_yy_xx_flush),
    .wb              (wb_if),
    .fcnvt_credit_ok (fcnvt_credit_ok),
    .fcnvt_buf_err   (fcnvt_buf_err)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  // Reference model state.
  ent_t q[$];
  int   m_credit;
  bit   m_err;

  // Upstream EX2/EX3 stage contents as seen by the bench.
  bit   st1_v, st2_v;
  ent_t st1, st2;

  int checks = 0;
  int errors = 0;
  int launches;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check outputs against the model, advance the model, clock.
  task automatic cycle(input bit rst, input bit e1, input bit e3, input ent_t e,
                       input bit g, input bit fl);
    bit pop;
    cpurst          = rst;
    ex1_pipedown    = e1;
    ex3_pipedown    = e3;
    ex3_result      = e.data;
    ex3_fflags      = e.ff;
    ex3_preg        = e.preg;
    wb_if.wb_grant  = g;
    rtu_yy_xx_flush = fl;
    #1;
    chk("wb_req", wb_if.wb_req, 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("wb_data", wb_if.wb_data, q[0].data);
      chk("wb_fflags", 64'(wb_if.wb_fflags), 64'(q[0].ff));
      chk("wb_preg", 64'(wb_if.wb_preg), 64'(q[0].preg));
    end
    chk("credit_ok", 64'(fcnvt_credit_ok), 64'(m_credit != 0));
    chk("buf_err", 64'(fcnvt_buf_err), 64'(m_err));

    pop = (q.size() != 0) && g;
    if (rst) begin
      q.delete();
      m_credit = DEPTH;
      m_err    = 1'b0;
    end else if (fl) begin
      q.delete();
      m_credit = DEPTH;
    end else begin
      if (e1 && m_credit == 0 && !pop) m_err = 1'b1;
      if (e3 && q.size() == DEPTH && !pop) m_err = 1'b1;
      if (g && q.size() == 0) m_err = 1'b1;
      // Credits: a launch takes one, a pop returns one; a refused launch changes nothing.
      if (e1 && !pop && m_credit > 0) m_credit--;
      else if (pop && !e1) m_credit++;
      if (e3 && (q.size() < DEPTH || pop)) begin
        if (pop) void'(q.pop_front());
        q.push_back(e);
      end else if (pop) begin
        void'(q.pop_front());
      end
    end
    @(posedge forever_cpuclk);
    #1;
  endtask

  function automatic ent_t rnd_ent();
    ent_t e;
    e.data = {$urandom, $urandom};
    e.ff   = 5'($urandom);
    e.preg = 7'($urandom);
    return e;
  endfunction

  // Cycle through the upstream pipe: launch in t reaches ex3_pipedown in t+2.
  task automatic pipe_cycle(input bit e1, input bit g, input bit fl, input ent_t e);
    cycle(1'b0, e1, st2_v, st2, g, fl);
    if (fl) begin
      st1_v = 1'b0;
      st2_v = 1'b0;
    end else begin
      st2_v = st1_v;
      st2   = st1;
      st1_v = e1;
      st1   = e;
    end
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    st1_v = 1'b0;
    st2_v = 1'b0;
  endtask

  // Drain with grant held whenever a request is pending.
  task automatic drain(input int n);
    for (int i = 0; i < n; i++) pipe_cycle(1'b0, q.size() != 0, 1'b0, rnd_ent());
  endtask

  // Launch with grant held low until credits are exhausted and the pipe has emptied.
  task automatic fill();
    launches = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_credit != 0) launches++;
      pipe_cycle(m_credit != 0, 1'b0, 1'b0, rnd_ent());
    end
  endtask

  initial begin
    ent_t e;
    cpurst = 1'b1; ex1_pipedown = 1'b0; ex3_pipedown = 1'b0; ex3_result = '0;
    ex3_fflags = '0; ex3_preg = '0; rtu_yy_xx_flush = 1'b0; wb_if.wb_grant = 1'b0;
    st1_v = 1'b0; st2_v = 1'b0; st1 = '0; st2 = '0;
    q.delete(); m_credit = DEPTH; m_err = 1'b0;
    repeat (2) @(posedge forever_cpuclk);
    #1;

    // Single op: launch at 0, result at 2, requested only in cycle 3.
    e.data = 64'h3FF0_0000_0000_0000; e.ff = 5'b00001; e.preg = 7'd12;
    pipe_cycle(1'b1, 1'b0, 1'b0, e);
    pipe_cycle(1'b0, 1'b0, 1'b0, rnd_ent());
    pipe_cycle(1'b0, 1'b0, 1'b0, rnd_ent());
    chk("single_req_c3", 64'(wb_if.wb_req), 64'd1);
    chk("single_data_c3", wb_if.wb_data, 64'h3FF0_0000_0000_0000);
    pipe_cycle(1'b0, 1'b1, 1'b0, rnd_ent());
    chk("single_req_c4", 64'(wb_if.wb_req), 64'd0);
    pipe_cycle(1'b0, 1'b0, 1'b0, rnd_ent());

    // Streaming: one launch per cycle with immediate grant; credit_ok must never drop.
    for (int i = 0; i < 24; i++) pipe_cycle(i < 20, q.size() != 0, 1'b0, rnd_ent());
    chk("stream_empty", 64'(wb_if.wb_req), 64'd0);
    chk("stream_err", 64'(fcnvt_buf_err), 64'd0);

    // Backpressure: exactly DEPTH launches fit, then four back-to-back pops.
    fill();
    chk("bp_launches", 64'(launches), 64'(DEPTH));
    chk("bp_credit_zero", 64'(fcnvt_credit_ok), 64'd0);
    drain(5);
    chk("bp_credit_back", 64'(fcnvt_credit_ok), 64'd1);

    // Full with simultaneous push and pop, walking the pointers through the wrap.
    fill();
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b1, rnd_ent(), 1'b1, 1'b0);
    chk("full_pp_err", 64'(fcnvt_buf_err), 64'd0);
    drain(5);

    // Push into a full buffer without a pop: dropped, flagged, contents intact.
    fill();
    cycle(1'b0, 1'b0, 1'b1, rnd_ent(), 1'b0, 1'b0);
    chk("push_full_err", 64'(fcnvt_buf_err), 64'd1);
    drain(5);
    do_reset();
    chk("err_cleared_rst", 64'(fcnvt_buf_err), 64'd0);

    // Launch with no credit: flagged and held until reset, flush does not clear it.
    fill();
    cycle(1'b0, 1'b1, 1'b0, rnd_ent(), 1'b0, 1'b0);
    chk("ex1_nocredit_err", 64'(fcnvt_buf_err), 64'd1);
    pipe_cycle(1'b0, 1'b0, 1'b1, rnd_ent());
    drain(3);
    chk("err_held", 64'(fcnvt_buf_err), 64'd1);
    do_reset();

    // Grant with nothing requested: ignored but flagged.
    cycle(1'b0, 1'b0, 1'b0, rnd_ent(), 1'b1, 1'b0);
    chk("grant_idle_err", 64'(fcnvt_buf_err), 64'd1);
    chk("grant_idle_req", 64'(wb_if.wb_req), 64'd0);
    drain(2);
    do_reset();

    // Flush with cnt=3, credit=0 and a push plus grant in the same cycle.
    for (int i = 0; i < 4; i++) pipe_cycle(1'b1, 1'b0, 1'b0, rnd_ent());
    pipe_cycle(1'b0, 1'b0, 1'b0, rnd_ent());
    chk("pre_flush_cnt3", 64'(q.size()), 64'd3);
    pipe_cycle(1'b0, 1'b1, 1'b1, rnd_ent());
    chk("flush_req", 64'(wb_if.wb_req), 64'd0);
    chk("flush_credit", 64'(fcnvt_credit_ok), 64'd1);
    drain(3);
    chk("flush_no_err", 64'(fcnvt_buf_err), 64'd0);

    // Randomized legal traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r == 0) begin
        do_reset();
      end else begin
        pipe_cycle((m_credit != 0) && ($urandom_range(0, 3) != 0),
                   (q.size() != 0) && ($urandom_range(0, 3) != 0),
                   r < 3, rnd_ent());
      end
    end
    drain(6);
    chk("rand_err", 64'(fcnvt_buf_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
